// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO that sits behind a uart_rx core. Each data_ready
// strobe offers one byte, which is written into a circular buffer unless it
// carries a framing error and DROP_FRAMING_ERR is set. The head entry is
// presented first-word-fall-through; the consumer pops it with rd_ready.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   data_received  in   [7:0] byte from uart_rx, valid with data_ready
//   data_ready     in   one-cycle strobe per received byte
//   framing_error  in   stop-bit error, sampled only with data_ready
//   rd_data        out  [7:0] head byte
//   rd_err         out  framing-error flag of the head byte
//   rd_valid       out  FIFO non-empty
//   rd_ready       in   consumer accepts head byte
//   count          out  [$clog2(DEPTH):0] stored bytes
//   full           out  count == DEPTH
//   overflow       out  sticky: a byte was lost to a full FIFO
//   overflow_clr   in   clears overflow (a same-cycle new overflow wins)
//   frame_err_cnt  out  [7:0] saturating count of framing-error strobes

module uart_rx_fifo #(
    parameter int DEPTH            = 16,
    parameter int DROP_FRAMING_ERR = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               data_received,
    input  logic                     data_ready,
    input  logic                     framing_error,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [7:0]               frame_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic KEEP_ERR = (DROP_FRAMING_ERR == 0);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    head;

    logic wr_req;
    logic pop;
    logic wr_en;
    logic ovf_set;

    assign wr_req  = data_ready & (~framing_error | KEEP_ERR);
    assign rd_valid = (count != '0);
    assign full     = (count == CNT_FULL);
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr_en    = wr_req & (~full | pop);
    assign ovf_set  = wr_req & full & ~pop;

    assign head    = mem[rd_ptr];
    assign rd_data = head[7:0];
    // Gated by rd_valid so stale memory never shows an error after reset.
    assign rd_err  = rd_valid & head[8] & KEEP_ERR;

    // Storage has no reset; contents are only meaningful between pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {framing_error & KEEP_ERR, data_received};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            frame_err_cnt <= 8'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (wr_en && !pop) begin
                count <= count + CNT_ONE;
            end else if (!wr_en && pop) begin
                count <= count - CNT_ONE;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            if (data_ready && framing_error && frame_err_cnt != 8'hFF) begin
                frame_err_cnt <= frame_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; power of two, 4..256.
REQ-002 SHALL have parameter DROP_FRAMING_ERR, default 1; 1 = discard bytes with framing errors, 0 = store them with an error flag.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_received  input  8  byte from uart_rx; valid when data_ready=1.
REQ-006 SHALL have port data_ready  input  1  one-cycle strobe from uart_rx, one per received byte.
REQ-007 SHALL have port framing_error  input  1  stop-bit error flag from uart_rx, sampled only in the data_ready cycle.
REQ-008 SHALL have port rd_data  output  8  head-of-FIFO byte.
REQ-009 SHALL have port rd_err  output  1  framing-error flag of the head byte; always 0 when DROP_FRAMING_ERR=1.
REQ-010 SHALL have port rd_valid  output  1  FIFO non-empty; rd_data and rd_err are valid.
REQ-011 SHALL have port rd_ready  input  1  consumer accepts the head byte.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-013 SHALL have port full  output  1  count==DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky flag: a byte was lost because the FIFO was full.
REQ-015 SHALL have port overflow_clr  input  1  clears overflow.
REQ-016 SHALL have port frame_err_cnt  output  8  saturating count of framing-error bytes received.

Function
REQ-017 SHALL store 9-bit entries {err, byte} in a DEPTH-entry circular buffer, with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 SHALL define a write request as data_ready=1, qualified by (framing_error=0 or DROP_FRAMING_ERR=0).
REQ-019 SHALL define a pop as rd_valid=1 and rd_ready=1 on the same rising edge.
REQ-020 SHALL present the head entry in first-word-fall-through mode: rd_data/rd_err = mem[rd_ptr] combinationally, rd_valid = (count!=0).
REQ-021 SHALL assert rd_valid the first cycle after the edge that samples a write into an empty FIFO (1-cycle latency).
REQ-022 SHALL ignore rd_ready when rd_valid=0; pointers and count SHALL not change.
REQ-023 SHALL accept a write when full if a pop occurs in the same cycle; count stays DEPTH.
REQ-024 SHALL, on a write request while full with no pop: drop the byte, leave mem/pointers/count unchanged, and set overflow.
REQ-025 SHALL, on a simultaneous write and pop when neither full nor empty, leave count unchanged and advance both pointers.
REQ-026 SHALL, when empty, never let a same-cycle write and rd_ready produce a pop.
REQ-027 SHALL increment frame_err_cnt on each data_ready with framing_error=1, whether or not the byte is stored, and hold it at 255 (saturate).
REQ-028 SHALL, when DROP_FRAMING_ERR=1, store no byte received with framing_error=1.
REQ-029 SHALL clear overflow on overflow_clr=1; if a new overflow occurs in the same cycle, set SHALL win.
REQ-030 SHALL treat framing_error=1 with data_ready=0 as no event.
REQ-031 SHALL generate full, count and overflow from registered state only, with no combinational path from the inputs.

Reset
REQ-032 SHALL, on reset low, immediately and asynchronously clear both pointers, count, overflow and frame_err_cnt; rd_valid=0, full=0, rd_err=0.
REQ-033 SHALL discard all stored bytes on reset asserted mid-operation; memory contents need not be cleared.
REQ-034 SHALL accept no write or pop on the first rising edge after reset deasserts while data_ready=0; normal operation SHALL begin on that edge.

Verification
REQ-035 SHALL cover: strobes 0x43 then 0x70 with framing_error=0, rd_ready=0 -> count=2, rd_data=0x43; one pop -> rd_data=0x70, count=1.
REQ-036 SHALL cover: DEPTH=16, 17 strobes with no pops -> full=1, count=16, overflow=1, first 16 bytes read back in order; pulse overflow_clr -> overflow=0.
REQ-037 SHALL cover: full FIFO, strobe 0xAA with rd_ready=1 in the same cycle -> count stays 16, overflow=0, 0xAA is the last byte read.
REQ-038 SHALL cover: DROP_FRAMING_ERR=1, strobe 0x39 with framing_error=1 -> count unchanged, frame_err_cnt=1; with DROP_FRAMING_ERR=0 -> stored with rd_err=1.
REQ-039 SHALL cover: 300 framing-error strobes -> frame_err_cnt=255.
REQ-040 SHALL cover: 5 bytes stored, reset pulsed low between clock edges -> count=0, rd_valid=0 with no clock edge; next strobe 0x55 -> rd_data=0x55.
